// File: rtl/ex_stage_mc.sv
// Registered execute stage: two-level forwarding, ALU, branch resolution, EX/MEM register.
// Define EX_MULDIV_EN to build the iterative multiply/divide unit (MUL/DIV/DONE states).
module ex_stage_mc #(
  parameter int XLEN = 32,
  parameter int OP_W = 4,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [OP_W-1:0] alu_op,
  input  logic            branch,
  input  logic [2:0]      bru_op,
  input  logic [PC_W-1:0] pc,
  input  logic [4:0]      rd,
  input  logic            regwrite,
  input  logic [4:0]      ex_mem_rd,
  input  logic [4:0]      mem_wb_rd,
  input  logic            ex_mem_regwrite,
  input  logic            mem_wb_regwrite,
  input  logic [XLEN-1:0] ex_mem_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_branch_taken,
  output logic [PC_W-1:0] out_target,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            busy
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MULHU = OP_W'(11);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_REMU  = OP_W'(13);

  logic [XLEN-1:0] op_a, op_b, alu_b, alu_y, sc_result;
  logic [SH_W-1:0] shamt;
  logic            cond, taken, is_jump;
  logic [PC_W-1:0] target;
  logic            accept, accept_sc;

  always_comb begin
    if (ex_mem_regwrite && ex_mem_rd == rs1 && rs1 != '0)      op_a = ex_mem_result;
    else if (mem_wb_regwrite && mem_wb_rd == rs1 && rs1 != '0) op_a = wb_result;
    else                                                       op_a = rs1_data;
    if (ex_mem_regwrite && ex_mem_rd == rs2 && rs2 != '0)      op_b = ex_mem_result;
    else if (mem_wb_regwrite && mem_wb_rd == rs2 && rs2 != '0) op_b = wb_result;
    else                                                       op_b = rs2_data;
  end

  assign alu_b = alu_src ? imm : op_b;
  assign shamt = alu_b[SH_W-1:0];

  always_comb begin
    alu_y = '0;
    case (alu_op)
      OP_ADD:  alu_y = op_a + alu_b;
      OP_SUB:  alu_y = op_a - alu_b;
      OP_AND:  alu_y = op_a & alu_b;
      OP_OR:   alu_y = op_a | alu_b;
      OP_XOR:  alu_y = op_a ^ alu_b;
      OP_SLL:  alu_y = op_a << shamt;
      OP_SRL:  alu_y = op_a >> shamt;
      OP_SRA:  alu_y = $signed(op_a) >>> shamt;
      OP_SLT:  alu_y = XLEN'($signed(op_a) < $signed(alu_b));
      OP_SLTU: alu_y = XLEN'(op_a < alu_b);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    cond   = 1'b0;
    target = pc + PC_W'(imm);
    case (bru_op)
      3'd0: cond = (op_a == op_b);
      3'd1: cond = (op_a != op_b);
      3'd2: cond = 1'b1;
      3'd3: begin
        cond   = 1'b1;
        target = PC_W'(op_a + imm) & ~PC_W'(1);
      end
      3'd4: cond = ($signed(op_a) <  $signed(op_b));
      3'd5: cond = ($signed(op_a) >= $signed(op_b));
      3'd6: cond = (op_a <  op_b);
      3'd7: cond = (op_a >= op_b);
      default: cond = 1'b0;
    endcase
  end

  assign taken     = branch && cond;
  assign is_jump   = branch && (bru_op == 3'd2 || bru_op == 3'd3);
  assign sc_result = is_jump ? XLEN'(pc + PC_W'(4)) : alu_y;
  assign accept    = in_valid && in_ready;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [XLEN-1:0]  md_hi, md_lo, md_m;
  logic [CNT_W-1:0] cnt;
  logic             md_sel, pend_regwrite;
  logic [4:0]       pend_rd;
  logic             is_mul, is_div, load_done;
  logic [XLEN:0]    sum, shifted, diff;

  assign is_mul    = (alu_op == OP_MUL)  || (alu_op == OP_MULHU);
  assign is_div    = (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept_sc = accept && !is_mul && !is_div;
  assign load_done = (state == DONE) && (!out_valid || out_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_nx = MUL;
        else if (accept && is_div) state_nx = DIV;
      end
      MUL, DIV: if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE:     if (load_done) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Shared registers: multiply keeps {hi,lo} as product, divide keeps hi=remainder, lo=quotient.
  assign sum     = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_m} : '0);
  assign shifted = {md_hi, md_lo[XLEN-1]};
  assign diff    = shifted - {1'b0, md_m};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_hi         <= '0;
      md_lo         <= '0;
      md_m          <= '0;
      cnt           <= '0;
      md_sel        <= 1'b0;
      pend_rd       <= '0;
      pend_regwrite <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && (is_mul || is_div)) begin
        md_hi         <= '0;
        md_lo         <= op_a;
        md_m          <= alu_b;
        cnt           <= CNT_W'(XLEN);
        md_sel        <= (alu_op == OP_MULHU) || (alu_op == OP_REMU);
        pend_rd       <= rd;
        pend_regwrite <= regwrite;
      end
    end else if (state == MUL) begin
      md_hi <= sum[XLEN:1];
      md_lo <= {sum[0], md_lo[XLEN-1:1]};
      cnt   <= cnt - CNT_W'(1);
    end else if (state == DIV) begin
      md_hi <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      md_lo <= {md_lo[XLEN-2:0], ~diff[XLEN]};
      cnt   <= cnt - CNT_W'(1);
    end
  end
`else
  assign in_ready  = (!out_valid || out_ready) && !flush;
  assign accept_sc = accept;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_result       <= '0;
      out_branch_taken <= 1'b0;
      out_target       <= '0;
      out_rd           <= '0;
      out_regwrite     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_sc) begin
      out_valid        <= 1'b1;
      out_result       <= sc_result;
      out_branch_taken <= taken;
      out_target       <= target;
      out_rd           <= rd;
      out_regwrite     <= regwrite;
`ifdef EX_MULDIV_EN
    end else if (load_done) begin
      out_valid        <= 1'b1;
      out_result       <= md_sel ? md_hi : md_lo;
      out_branch_taken <= 1'b0;
      out_target       <= '0;
      out_rd           <= pend_rd;
      out_regwrite     <= pend_regwrite;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Directed-vector bench for ex_stage_mc; expectations follow the EX_MULDIV_EN build setting.
module tb_ex_stage_mc;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [4:0]  rs1, rs2, rd, ex_mem_rd, mem_wb_rd, out_rd;
  logic [31:0] rs1_data, rs2_data, imm, ex_mem_result, wb_result, out_result;
  logic        alu_src, branch, regwrite, ex_mem_regwrite, mem_wb_regwrite;
  logic [3:0]  alu_op;
  logic [2:0]  bru_op;
  logic [31:0] pc, out_target;
  logic        out_valid, out_ready, out_branch_taken, out_regwrite, busy;

  int checks = 0;
  int errors = 0;

  ex_stage_mc #(.XLEN(32), .OP_W(4), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .bru_op(bru_op), .pc(pc),
    .rd(rd), .regwrite(regwrite), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
    .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
    .ex_mem_result(ex_mem_result), .wb_result(wb_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_branch_taken(out_branch_taken),
    .out_target(out_target), .out_rd(out_rd), .out_regwrite(out_regwrite), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic [31:0] im);
    rs1 = 5'd1; rs2 = 5'd2; rs1_data = a; rs2_data = b;
    alu_op = op; alu_src = src; imm = im;
    branch = 1'b0; bru_op = 3'd0; pc = 32'h0;
    rd = 5'd9; regwrite = 1'b1;
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
  endtask

  // Holds in_valid until the stage accepts; returns 1 time unit after the accept edge.
  task automatic fire();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("accept_wait", {63'b0, n < 100}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic alu_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    set_alu(op, a, b, 1'b0, 32'h0);
    fire();
    check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    check(tag, {32'b0, out_result}, {32'b0, exp});
  endtask

  task automatic md_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    logic ok = 1'b1;
    set_alu(op, a, b, 1'b0, 32'h0);
    fire();
`ifdef EX_MULDIV_EN
    while (!out_valid && n < 100) begin
      if (!busy || in_ready) ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_stall"}, {63'b0, ok}, 64'd1);
    check(tag, {32'b0, out_result}, {32'b0, exp});
`else
    check({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    check({tag, "_nomd"}, {32'b0, out_result}, 64'd0);
    check({tag, "_busy"}, {63'b0, busy}, 64'd0);
    if (exp == 32'hDEAD_BEEF) check(tag, 64'd0, 64'd1);
`endif
    check({tag, "_rd"}, {59'b0, out_rd}, 64'd9);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ex_mem_rd = '0; mem_wb_rd = '0; ex_mem_result = '0; wb_result = '0;
    set_alu(4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    #2;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_result", {32'b0, out_result}, 64'd0);
    check("rst_out_target", {32'b0, out_target}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_out_regwrite", {63'b0, out_regwrite}, 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    alu_vec("add", 4'd0, 32'd5, 32'd7, 32'd12);
    check("add_rd", {59'b0, out_rd}, 64'd9);
    check("add_regwrite", {63'b0, out_regwrite}, 64'd1);
    alu_vec("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu_vec("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu_vec("xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu_vec("sll_wrap", 4'd5, 32'd3, 32'd33, 32'd6);
    alu_vec("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
    alu_vec("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_vec("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("op14", 4'd14, 32'd5, 32'd7, 32'd0);

    // Forwarding priority: MEM beats WB; x0 never forwards.
    set_alu(4'd0, 32'd55, 32'd0, 1'b1, 32'd1);
    rs1 = 5'd3; ex_mem_rd = 5'd3; ex_mem_regwrite = 1'b1; ex_mem_result = 32'd100;
    mem_wb_rd = 5'd3; mem_wb_regwrite = 1'b1; wb_result = 32'd200;
    fire();
    check("fwd_mem", {32'b0, out_result}, 64'd101);
    rs1 = 5'd0; rs1_data = 32'd0;
    fire();
    check("fwd_x0", {32'b0, out_result}, 64'd1);
    rs1 = 5'd3; ex_mem_regwrite = 1'b0;
    fire();
    check("fwd_wb", {32'b0, out_result}, 64'd201);
    rs1 = 5'd0; rs2 = 5'd3; alu_src = 1'b0; ex_mem_regwrite = 1'b1;
    fire();
    check("fwd_b_mem", {32'b0, out_result}, 64'd100);

    set_alu(4'd0, 32'd4, 32'd5, 1'b0, 32'hFFFF_FFF8);
    branch = 1'b1; bru_op = 3'd1; pc = 32'h40;
    fire();
    check("bne_taken", {63'b0, out_branch_taken}, 64'd1);
    check("bne_target", {32'b0, out_target}, 64'h38);
    bru_op = 3'd0;
    fire();
    check("beq_not_taken", {63'b0, out_branch_taken}, 64'd0);
    bru_op = 3'd6; rs1_data = 32'hFFFF_FFFF;
    fire();
    check("bltu_not_taken", {63'b0, out_branch_taken}, 64'd0);
    bru_op = 3'd4;
    fire();
    check("blt_taken", {63'b0, out_branch_taken}, 64'd1);

    set_alu(4'd0, 32'h101, 32'd0, 1'b1, 32'd4);
    branch = 1'b1; bru_op = 3'd3; pc = 32'h10;
    fire();
    check("jalr_taken", {63'b0, out_branch_taken}, 64'd1);
    check("jalr_target", {32'b0, out_target}, 64'h104);
    check("jalr_link", {32'b0, out_result}, 64'h14);

    md_vec("mulhu", 4'd11, 32'hFFFF_FFFF, 32'd2, 32'd1);
    md_vec("mul", 4'd10, 32'd6, 32'd7, 32'd42);
    md_vec("divu_by0", 4'd12, 32'd100, 32'd0, 32'hFFFF_FFFF);
    md_vec("remu_by0", 4'd13, 32'd100, 32'd0, 32'd100);
    md_vec("remu", 4'd13, 32'd100, 32'd7, 32'd2);
    md_vec("divu", 4'd12, 32'd100, 32'd7, 32'd14);

    // Back-pressure: output must hold while MEM is not ready.
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_alu(4'd0, 32'd5, 32'd7, 1'b0, 32'd0);
    fire();
    rs1_data = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_result", {32'b0, out_result}, 64'd12);
      check("stall_valid", {63'b0, out_valid}, 64'd1);
      check("stall_in_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", {63'b0, out_valid}, 64'd0);

    out_ready = 1'b0;
    fire();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b1;
    check("flush_out_reg", {63'b0, out_valid}, 64'd0);

    set_alu(4'd0, 32'd1, 32'd1, 1'b0, 32'd0);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_drop", {63'b0, out_valid}, 64'd0);

`ifdef EX_MULDIV_EN
    set_alu(4'd12, 32'd100, 32'd7, 1'b0, 32'd0);
    fire();
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_div_busy", {63'b0, busy}, 64'd0);
    check("flush_div_valid", {63'b0, out_valid}, 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_div_no_result", 64'(seen), 64'd0);

    set_alu(4'd10, 32'd3, 32'd3, 1'b0, 32'd0);
    fire();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'b0, busy}, 64'd0);
    check("rst_mid_valid", {63'b0, out_valid}, 64'd0);
    rst_n = 1'b1;
`else
    seen = 0;
`endif
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised, registered successor to the execute stage. Adds two-level operand forwarding, single-cycle ALU and branch resolution, and an optional iterative multiply/divide unit.
- Sits between the ID/EX register and the MEM stage, and owns the EX/MEM output register.
- Uses a valid/ready handshake on both sides so that multi-cycle operations can stall the front end.

Parameters:
XLEN, 32, datapath width (≥8, power of two)
OP_W, 4, ALU opcode width
PC_W, 32, program counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of in-flight and output-register instruction
in_valid  in  1  issue request from ID/EX
in_ready  out  1  stage can accept this cycle
rs1, rs2  in  5 each  source register numbers
rs1_data, rs2_data  in  XLEN each  register file read data
imm  in  XLEN  immediate
alu_src  in  1  1: operand B = imm
alu_op  in  OP_W  ALU opcode
branch  in  1  instruction is branch/jump
bru_op  in  3  branch opcode
pc  in  PC_W  instruction PC
rd  in  5  destination register
regwrite  in  1  writes rd
ex_mem_rd, mem_wb_rd  in  5 each  forwarding destinations
ex_mem_regwrite, mem_wb_regwrite  in  1 each  forwarding enables
ex_mem_result, wb_result  in  XLEN each  forwarding data
out_valid  out  1  EX/MEM register holds a valid instruction
out_ready  in  1  MEM accepts the output
out_result  out  XLEN  ALU, mul/div or link result
out_branch_taken  out  1  branch/jump taken
out_target  out  PC_W  branch/jump target
out_rd  out  5  destination register
out_regwrite  out  1  write enable
busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid, out_result, out_branch_taken, out_target, out_rd, out_regwrite, busy all 0; counter 0.
- Forwarding:
  - Operand A = ex_mem_result if ex_mem_regwrite && ex_mem_rd==rs1 && rs1!=0; else wb_result under the same test on the mem_wb_* inputs; else rs1_data.
  - Operand B is resolved the same way using rs2 and rs2_data.
  - The MEM-stage match has priority over the WB-stage match.
  - Forwarded operands are sampled only in the accept cycle.
- ALU input 2 = alu_src ? imm : operand B.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount = low log2(XLEN) bits)
  - 8 SLT, 9 SLTU
  - 10 MUL (low XLEN), 11 MULHU, 12 DIVU, 13 REMU
  - 14–15 result 0
- bru_op encoding and branch outcome (branch=1):
  - 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU: compare operand A against operand B; target = pc+imm.
  - 2 JAL: always taken, target = pc+imm.
  - 3 JALR: always taken, target = (A+imm) with bit0 cleared.
  - JAL/JALR: out_result = pc+4, overriding the ALU result.
  - branch=0: out_branch_taken is 0.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - Accept when in_valid && in_ready.
  - Output register holds all fields stable while out_valid && !out_ready.
  - out_valid clears when out_ready is high and no new result loads.
- Latency:
  - Single-cycle ops: result visible 1 cycle after accept.
  - Mul/div ops: state → MUL or DIV, counter=XLEN, busy=1. One shift-add or restoring-subtract step per cycle. After XLEN steps → DONE.
  - DONE loads the output register when !out_valid || out_ready, then → IDLE.
  - Minimum latency XLEN+1 cycles.
- State machine:
  - IDLE → MUL (ops 10–11) or IDLE → DIV (ops 12–13) on accept.
  - MUL/DIV decrement counter; counter==1 → DONE.
  - DONE → IDLE on load.
- Divide by zero: quotient all-ones, remainder = dividend, same latency.
- flush:
  - Clears out_valid, forces state IDLE, busy 0.
  - Flush wins over a simultaneous accept; the instruction is dropped.
  - Flush in DONE discards the result.
- Reset mid-operation: asynchronous, returns to reset values immediately.

Optional Feature:
EX_MULDIV_EN
- Defined: iterative mul/div datapath and the MUL/DIV/DONE states are present, as described above.
- Undefined: ops 10–13 complete in 1 cycle with out_result=0, only the IDLE state exists, and busy is tied 0.

Test Plan:
- XLEN=32, rs1_data=5, rs2_data=7, alu_op=0, alu_src=0 → out_result=12, out_valid 1 cycle after accept.
- ex_mem_rd=3, ex_mem_regwrite=1, ex_mem_result=100, mem_wb_rd=3, mem_wb_regwrite=1, wb_result=200, rs1=3, imm=1, alu_src=1, ADD → 101. Repeat with rs1=0, rs1_data=0 → 1.
- EX_MULDIV_EN: A=0xFFFF_FFFF, B=2, MULHU → out_result=1 after 33 cycles; busy=1 and in_ready=0 throughout.
- DIVU 100/0 → out_result=0xFFFF_FFFF. REMU 100/7 → 2.
- BNE 4≠5, pc=0x40, imm=-8 → out_branch_taken=1, out_target=0x38. JALR A=0x101, imm=4, pc=0x10 → out_target=0x104, out_result=0x14.
- out_ready=0 for 3 cycles after a result → outputs stable, in_ready=0. flush during DIV at cycle 10 → out_valid stays 0, busy=0 next cycle.
